// File: rtl/coinc_pkg.sv
// coinc_pkg: shared types and constants for the coincidence detector.
// Imported by coinc_cond and coincidence_detector.
package coinc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DET
  } coinc_state_t;

  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

endpackage

// File: rtl/coinc_cond.sv
// coinc_cond: combinational AND/OR combine of the masked input lines.
// An empty mask never qualifies, in either mode.
module coinc_cond
  import coinc_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         mode,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] a,
  output logic         cond
);

  logic any_en;
  logic and_c;
  logic or_c;

  assign any_en = |mask;
  assign and_c  = &(a | ~mask);
  assign or_c   = |(a & mask);

  always_comb begin
    cond = 1'b0;
    if (any_en) begin
      cond = (mode == MODE_OR) ? or_c : and_c;
    end
  end

endmodule

// File: rtl/coincidence_detector.sv
// coincidence_detector: masked AND/OR coincidence with HOLD-cycle filter.
// Define COINC_EVCOUNT_EN to build the saturating detection counter.
module coincidence_detector
  import coinc_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 4,
  parameter int EVW  = 8,
  localparam int CW  = $clog2(HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clear,
  input  logic           mode,
  input  logic [N-1:0]   mask,
  input  logic [N-1:0]   a,
  output logic           x,
  output logic           rise,
  output logic [CW-1:0]  run_cnt,
  output logic [EVW-1:0] ev_count
);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  coinc_state_t    state_q;
  coinc_state_t    state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            x_q;
  logic            rise_q;
  logic            enter;
  logic            cond;

  coinc_cond #(
    .N(N)
  ) u_cond (
    .mode(mode),
    .mask(mask),
    .a   (a),
    .cond(cond)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (cond) begin
            cnt_d = ONE_C;
            if (HOLD == 1) begin
              state_d = DET;
              enter   = 1'b1;
            end else begin
              state_d = ARM;
            end
          end
        end
        ARM: begin
          if (cond) begin
            cnt_d = cnt_q + ONE_C;
            if (cnt_d == HOLD_C) begin
              state_d = DET;
              enter   = 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        DET: begin
          if (!cond) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Soft clear shares the reset path so it also blocks a same-edge entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= (state_d == DET);
      rise_q  <= enter;
    end
  end

`ifdef COINC_EVCOUNT_EN
  logic [EVW-1:0] ev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_q <= '0;
    end else if (clear) begin
      ev_q <= '0;
    end else if (enter && (ev_q != '1)) begin
      ev_q <= ev_q + 1'b1;
    end
  end

  assign ev_count = ev_q;
`else
  assign ev_count = '0;
`endif

  assign x       = x_q;
  assign rise    = rise_q;
  assign run_cnt = cnt_q;

endmodule
